// File: rtl/pipe_hazard_if.sv
// rtl/pipe_hazard_if.sv - pipeline status in / stage controls out bundle for pipe_hazard_ctrl
interface pipe_hazard_if;
    logic [4:0]  id_rs1;
    logic [4:0]  id_rs2;
    logic        id_use_rs1;
    logic        id_use_rs2;
    logic [4:0]  ex_rd;
    logic        ex_reg_write;
    logic        ex_mem_read;
    logic [4:0]  mem_rd;
    logic        mem_reg_write;
    logic        ex_branch_taken;
    logic        mem_access;
    logic        dmem_ack;
    logic        pc_we;
    logic        ifid_we;
    logic        idex_we;
    logic        exmem_we;
    logic        memwb_we;
    logic        ifid_zero;
    logic        idex_zero;
    logic        exmem_zero;
    logic        memwb_zero;
    logic        mem_fault;
    logic [31:0] stall_cycles;

    modport master (
        output id_rs1, id_rs2, id_use_rs1, id_use_rs2, ex_rd, ex_reg_write, ex_mem_read,
               mem_rd, mem_reg_write, ex_branch_taken, mem_access, dmem_ack,
        input  pc_we, ifid_we, idex_we, exmem_we, memwb_we,
               ifid_zero, idex_zero, exmem_zero, memwb_zero, mem_fault, stall_cycles
    );

    modport slave (
        input  id_rs1, id_rs2, id_use_rs1, id_use_rs2, ex_rd, ex_reg_write, ex_mem_read,
               mem_rd, mem_reg_write, ex_branch_taken, mem_access, dmem_ack,
        output pc_we, ifid_we, idex_we, exmem_we, memwb_we,
               ifid_zero, idex_zero, exmem_zero, memwb_zero, mem_fault, stall_cycles
    );
endinterface

// File: rtl/pipe_hazard_ctrl.sv
// rtl/pipe_hazard_ctrl.sv - 5-stage pipeline stall/flush/fault sequencer (option: PIPE_FORWARD_EN)
module pipe_hazard_ctrl #(
    parameter int MEM_TIMEOUT = 16
) (
    input  logic         clk,
    input  logic         rst,
    pipe_hazard_if.slave bus
);
    localparam int CW = $clog2(MEM_TIMEOUT + 1);

    typedef enum logic [1:0] {ST_RUN, ST_WAIT, ST_FAULT} state_t;

    state_t        state;
    logic [CW-1:0] wait_cnt;
    logic          mem_stall;
    logic          hazard;
    logic          ex_match;
    logic          mem_match;

    function automatic logic src_match(input logic [4:0] rd, input logic [4:0] rs1,
                                       input logic [4:0] rs2, input logic use1,
                                       input logic use2);
        return (rd != 5'd0) && ((use1 && rs1 == rd) || (use2 && rs2 == rd));
    endfunction

    assign ex_match  = src_match(bus.ex_rd, bus.id_rs1, bus.id_rs2, bus.id_use_rs1, bus.id_use_rs2);
    assign mem_match = src_match(bus.mem_rd, bus.id_rs1, bus.id_rs2, bus.id_use_rs1, bus.id_use_rs2);
    assign mem_stall = bus.mem_access && !bus.dmem_ack;

`ifdef PIPE_FORWARD_EN
    // Forwarding covers everything except a load result that is not yet read from memory.
    assign hazard = bus.ex_mem_read && bus.ex_reg_write && ex_match;
`else
    assign hazard = (bus.ex_reg_write && ex_match) || (bus.mem_reg_write && mem_match);
    logic unused_ex_mem_read;
    assign unused_ex_mem_read = bus.ex_mem_read;
`endif

    always_comb begin
        bus.pc_we      = 1'b0;
        bus.ifid_we    = 1'b0;
        bus.idex_we    = 1'b0;
        bus.exmem_we   = 1'b0;
        bus.memwb_we   = 1'b0;
        bus.ifid_zero  = 1'b0;
        bus.idex_zero  = 1'b0;
        bus.exmem_zero = 1'b0;
        bus.memwb_zero = 1'b0;
        bus.mem_fault  = 1'b0;
        if (rst) begin
            // all controls held low
        end else if (state == ST_FAULT) begin
            bus.mem_fault = 1'b1;
        end else if (mem_stall) begin
            // Upstream stages freeze (a taken branch waits in EX); WB gets a bubble.
            bus.memwb_we   = 1'b1;
            bus.memwb_zero = 1'b1;
        end else if (bus.ex_branch_taken) begin
            bus.pc_we     = 1'b1;
            bus.ifid_we   = 1'b1;
            bus.idex_we   = 1'b1;
            bus.exmem_we  = 1'b1;
            bus.memwb_we  = 1'b1;
            bus.ifid_zero = 1'b1;
            bus.idex_zero = 1'b1;
        end else if (hazard) begin
            bus.idex_we   = 1'b1;
            bus.idex_zero = 1'b1;
            bus.exmem_we  = 1'b1;
            bus.memwb_we  = 1'b1;
        end else begin
            bus.pc_we    = 1'b1;
            bus.ifid_we  = 1'b1;
            bus.idex_we  = 1'b1;
            bus.exmem_we = 1'b1;
            bus.memwb_we = 1'b1;
        end
    end

    // wait_cnt holds the stalled cycles already completed for the current access, so the
    // edge that closes the MEM_TIMEOUT-th stalled cycle is the one that enters FAULT.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state            <= ST_RUN;
            wait_cnt         <= '0;
            bus.stall_cycles <= 32'd0;
        end else begin
            if (state != ST_FAULT && !bus.pc_we && bus.stall_cycles != 32'hFFFF_FFFF)
                bus.stall_cycles <= bus.stall_cycles + 32'd1;
            case (state)
                ST_RUN: begin
                    if (mem_stall) begin
                        state    <= ST_WAIT;
                        wait_cnt <= CW'(1);
                    end
                end
                ST_WAIT: begin
                    if (bus.dmem_ack) begin
                        state    <= ST_RUN;
                        wait_cnt <= '0;
                    end else if (wait_cnt == CW'(MEM_TIMEOUT - 1)) begin
                        state <= ST_FAULT;
                    end else begin
                        wait_cnt <= wait_cnt + CW'(1);
                    end
                end
                default: state <= ST_FAULT;
            endcase
        end
    end
endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// tb/tb_pipe_hazard_ctrl.sv - scoreboard bench for pipe_hazard_ctrl with directed vectors
module tb_pipe_hazard_ctrl;
`ifdef PIPE_FORWARD_EN
    localparam bit FWD = 1'b1;
`else
    localparam bit FWD = 1'b0;
`endif
    localparam logic [31:0] S = FWD ? 32'd0 : 32'd2;
    localparam logic [31:0] T = FWD ? 32'd1 : 32'd4;

    typedef struct {
        string       name;
        logic [4:0]  we;
        logic [3:0]  zero;
        logic        fault;
        logic [31:0] sc;
    } exp_t;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   n_vec = 0;
    int   n_bad = 0;
    exp_t exp_q[$];

    pipe_hazard_if bus();
    pipe_hazard_ctrl #(.MEM_TIMEOUT(4)) dut (.clk(clk), .rst(rst), .bus(bus));

    always #5 clk = ~clk;

    task automatic push(input string nm, input logic [4:0] we, input logic [3:0] zero,
                        input logic fault, input logic [31:0] sc);
        exp_t e;
        e.name = nm; e.we = we; e.zero = zero; e.fault = fault; e.sc = sc;
        exp_q.push_back(e);
    endtask

    task automatic drive(input logic [4:0] rs1, input logic [4:0] rs2, input logic u1,
                         input logic u2, input logic [4:0] exrd, input logic exw,
                         input logic exl, input logic [4:0] memrd, input logic memw,
                         input logic br, input logic macc, input logic ack);
        bus.id_rs1 = rs1; bus.id_rs2 = rs2; bus.id_use_rs1 = u1; bus.id_use_rs2 = u2;
        bus.ex_rd = exrd; bus.ex_reg_write = exw; bus.ex_mem_read = exl;
        bus.mem_rd = memrd; bus.mem_reg_write = memw; bus.ex_branch_taken = br;
        bus.mem_access = macc; bus.dmem_ack = ack;
    endtask

    task automatic apply(input string nm, input logic [4:0] rs1, input logic [4:0] rs2,
                         input logic u1, input logic u2, input logic [4:0] exrd,
                         input logic exw, input logic exl, input logic [4:0] memrd,
                         input logic memw, input logic br, input logic macc, input logic ack,
                         input logic [4:0] we, input logic [3:0] zero, input logic fault,
                         input logic [31:0] sc);
        @(posedge clk);
        #1;
        drive(rs1, rs2, u1, u2, exrd, exw, exl, memrd, memw, br, macc, ack);
        push(nm, we, zero, fault, sc);
    endtask

    task automatic idle(input string nm, input logic [31:0] sc);
        apply(nm, 5'd0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0,
              5'b11111, 4'b0000, 1'b0, sc);
    endtask

    // Monitor: one expected entry is retired per cycle, sampled mid-cycle.
    always @(negedge clk) begin
        if (exp_q.size() > 0) begin
            exp_t e;
            logic [4:0] a_we;
            logic [3:0] a_zero;
            e = exp_q.pop_front();
            a_we   = {bus.pc_we, bus.ifid_we, bus.idex_we, bus.exmem_we, bus.memwb_we};
            a_zero = {bus.ifid_zero, bus.idex_zero, bus.exmem_zero, bus.memwb_zero};
            n_vec++;
            if (a_we !== e.we || a_zero !== e.zero || bus.mem_fault !== e.fault ||
                bus.stall_cycles !== e.sc) begin
                n_bad++;
                $display("FAIL %s: got we=%b zero=%b fault=%b sc=%0d, want we=%b zero=%b fault=%b sc=%0d",
                         e.name, a_we, a_zero, bus.mem_fault, bus.stall_cycles,
                         e.we, e.zero, e.fault, e.sc);
            end
        end
    end

    initial begin
        drive(5'd0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0);
        @(posedge clk);
        #1;
        push("reset_hold", 5'b00000, 4'b0000, 1'b0, 32'd0);
        @(negedge clk);
        #1 rst = 1'b0;

        idle("idle_after_reset", 32'd0);
        apply("alu_hazard_ex", 5'd0, 5'd7, 1'b0, 1'b1, 5'd7, 1'b1, 1'b0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0,
              FWD ? 5'b11111 : 5'b00111, FWD ? 4'b0000 : 4'b0100, 1'b0, 32'd0);
        apply("alu_hazard_mem", 5'd0, 5'd7, 1'b0, 1'b1, 5'd0, 1'b0, 1'b0, 5'd7, 1'b1, 1'b0, 1'b0, 1'b0,
              FWD ? 5'b11111 : 5'b00111, FWD ? 4'b0000 : 4'b0100, 1'b0, FWD ? 32'd0 : 32'd1);
        idle("alu_hazard_clear", S);
        apply("load_use_ex", 5'd5, 5'd0, 1'b1, 1'b0, 5'd5, 1'b1, 1'b1, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0,
              5'b00111, 4'b0100, 1'b0, S);
        apply("load_use_mem", 5'd5, 5'd0, 1'b1, 1'b0, 5'd0, 1'b0, 1'b0, 5'd5, 1'b1, 1'b0, 1'b0, 1'b0,
              FWD ? 5'b11111 : 5'b00111, FWD ? 4'b0000 : 4'b0100, 1'b0, S + 32'd1);
        apply("x0_no_hazard", 5'd0, 5'd0, 1'b1, 1'b1, 5'd0, 1'b1, 1'b1, 5'd0, 1'b1, 1'b0, 1'b0, 1'b0,
              5'b11111, 4'b0000, 1'b0, T);
        apply("branch_over_hazard", 5'd5, 5'd0, 1'b1, 1'b0, 5'd5, 1'b1, 1'b1, 5'd0, 1'b0, 1'b1, 1'b0, 1'b0,
              5'b11111, 4'b1100, 1'b0, T);
        apply("mem_stall_1_branch", 5'd0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b1, 1'b1, 1'b0,
              5'b00001, 4'b0001, 1'b0, T);
        apply("mem_stall_2", 5'd0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b1, 1'b0,
              5'b00001, 4'b0001, 1'b0, T + 32'd1);
        apply("mem_stall_3", 5'd0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b1, 1'b0,
              5'b00001, 4'b0001, 1'b0, T + 32'd2);
        apply("mem_ack", 5'd0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b1, 1'b1,
              5'b11111, 4'b0000, 1'b0, T + 32'd3);
        for (int i = 0; i < 4; i++)
            apply($sformatf("timeout_stall_%0d", i + 1), 5'd0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b0,
                  5'd0, 1'b0, 1'b0, 1'b1, 1'b0, 5'b00001, 4'b0001, 1'b0, T + 32'd3 + 32'(i));
        apply("fault_enter", 5'd0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b1, 1'b0,
              5'b00000, 4'b0000, 1'b1, T + 32'd7);
        apply("fault_sticky", 5'd0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b1,
              5'b00000, 4'b0000, 1'b1, T + 32'd7);

        @(posedge clk);
        #1 rst = 1'b1;
        push("async_reset_in_fault", 5'b00000, 4'b0000, 1'b0, 32'd0);
        @(negedge clk);
        #1 rst = 1'b0;
        idle("run_after_reset", 32'd0);

        for (int i = 0; i < 10 && exp_q.size() > 0; i++) @(negedge clk);
        #1;
        if (exp_q.size() > 0) begin
            n_bad++;
            $display("FAIL drain: got %0d pending, want 0", exp_q.size());
        end
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end
endmodule
